// File: rtl/ahb_lite_burst_manager.sv
// AHB-Lite manager: turns one burst command into a pipelined sequence of
// NONSEQ/SEQ address phases with overlapping data phases. Honours HREADY
// wait states and abandons the burst on a two-cycle ERROR response.
//
// Handshake: a command transfers on a rising clk edge where
// cmd_valid & cmd_ready are both high; cmd_ready is high only in IDLE, so the
// command fields must stay stable while cmd_valid waits for cmd_ready.
module ahb_lite_burst_manager #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [2:0]            cmd_burst,
    input  logic [2:0]            cmd_size,
    input  logic [4:0]            cmd_len,
    input  logic [3:0]            cmd_prot,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_pop,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    output logic                  done,
    output logic                  xfer_err,
    output logic                  cmd_err,
    output logic [ADDR_WIDTH-1:0] HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic [DATA_WIDTH-1:0] HWDATA,
    input  logic [DATA_WIDTH-1:0] HRDATA,
    input  logic                  HREADY,
    input  logic                  HRESP
);
    localparam int MAX_SIZE = $clog2(DATA_WIDTH / 8);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ADDR  = 3'd1,
        S_BURST = 3'd2,
        S_LAST  = 3'd3,
        S_ERR   = 3'd4
    } state_t;

    state_t state, state_nx;

    // burst context held for the whole burst
    logic                  wr_q;
    logic [2:0]            size_q;
    logic [2:0]            burst_q;
    logic [3:0]            prot_q;
    logic [4:0]            beats_q;   // total beats, sizes the wrap window
    logic [4:0]            left;      // address phases still to be accepted
    logic                  dp_valid;  // a data phase is in progress
    logic                  dp_last;   // that data phase is the final beat

    // strobes from the FSM
    logic accept, reject, addr_acc, dp_ok, err_hit, abort;

    function automatic logic [4:0] beats_of(input logic [2:0] b, input logic [4:0] len);
        case (b)
            3'd0:       beats_of = 5'd1;
            3'd1:       beats_of = len;
            3'd2, 3'd3: beats_of = 5'd4;
            3'd4, 3'd5: beats_of = 5'd8;
            default:    beats_of = 5'd16;
        endcase
    endfunction

    // command legality
    logic [4:0]            c_beats;
    logic [ADDR_WIDTH-1:0] c_incr, c_end;
    logic                  illegal;

    // legality of the offered command, evaluated every cycle
    always_comb begin
        c_beats = beats_of(cmd_burst, cmd_len);
        c_incr  = ADDR_WIDTH'(1) << cmd_size;
        c_end   = cmd_addr + (ADDR_WIDTH'(c_beats) << cmd_size) - ADDR_WIDTH'(1);
        illegal = (cmd_size > 3'(MAX_SIZE))
                | ((cmd_addr & (c_incr - ADDR_WIDTH'(1))) != '0)
                | ((cmd_burst == 3'd1) && (cmd_len == 5'd0))
                | (cmd_burst[0] && (((cmd_addr ^ c_end) >> 10) != '0));
    end

    // next beat address: plain increment, or increment inside the wrap window
    logic [ADDR_WIDTH-1:0] addr_inc, wrap_mask, addr_next;
    logic                  is_wrap;
    always_comb begin
        is_wrap   = ~burst_q[0] & (burst_q != 3'd0);
        addr_inc  = HADDR + (ADDR_WIDTH'(1) << size_q);
        wrap_mask = (ADDR_WIDTH'(beats_q) << size_q) - ADDR_WIDTH'(1);
        addr_next = is_wrap ? ((HADDR & ~wrap_mask) | (addr_inc & wrap_mask)) : addr_inc;
    end

    // state register
    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) state <= S_IDLE;
        else        state <= state_nx;
    end

    // next state, bus control outputs and strobes
    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        HTRANS    = 2'b00;
        HWRITE    = 1'b0;
        HSIZE     = 3'd0;
        HBURST    = 3'd0;
        HPROT     = 4'd0;
        err_hit   = dp_valid & HRESP;
        dp_ok     = dp_valid & HREADY & ~HRESP;
        accept    = 1'b0;
        reject    = 1'b0;
        addr_acc  = 1'b0;
        abort     = 1'b0;
        case (state)
            S_IDLE: begin
                cmd_ready = ~HRESET;
                if (cmd_valid && !HRESET) begin
                    accept = ~illegal;
                    reject = illegal;
                    if (!illegal) state_nx = S_ADDR;
                end
            end
            S_ADDR, S_BURST: begin
                HTRANS   = (state == S_ADDR) ? 2'b10 : 2'b11;
                HWRITE   = wr_q;
                HSIZE    = size_q;
                HBURST   = burst_q;
                HPROT    = prot_q;
                addr_acc = HREADY & ~err_hit;
                if (err_hit) begin
                    abort    = HREADY;
                    state_nx = HREADY ? S_IDLE : S_ERR;
                end else if (HREADY) begin
                    state_nx = (left == 5'd1) ? S_LAST : S_BURST;
                end
            end
            S_LAST: begin
                if (err_hit) begin
                    abort    = HREADY;
                    state_nx = HREADY ? S_IDLE : S_ERR;
                end else if (HREADY) begin
                    state_nx = S_IDLE;
                end
            end
            S_ERR: begin
                abort = HREADY;
                if (HREADY) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        wr_pop = addr_acc & wr_q;
    end

    // burst context, address/data registers and completion pulses
    always_ff @(posedge clk or posedge HRESET) begin
        if (HRESET) begin
            wr_q     <= 1'b0;
            size_q   <= 3'd0;
            burst_q  <= 3'd0;
            prot_q   <= 4'd0;
            beats_q  <= 5'd0;
            left     <= 5'd0;
            dp_valid <= 1'b0;
            dp_last  <= 1'b0;
            HADDR    <= '0;
            HWDATA   <= '0;
            rd_data  <= '0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            done     <= 1'b0;
            xfer_err <= 1'b0;
            cmd_err  <= 1'b0;
        end else begin
            done     <= 1'b0;
            xfer_err <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            cmd_err  <= reject;
            if (accept) begin
                wr_q     <= cmd_write;
                size_q   <= cmd_size;
                burst_q  <= cmd_burst;
                prot_q   <= cmd_prot;
                beats_q  <= c_beats;
                left     <= c_beats;
                HADDR    <= cmd_addr;
                dp_valid <= 1'b0;
            end
            if (addr_acc) begin
                // the final address stays on HADDR through the trailing IDLE
                if (left != 5'd1) HADDR <= addr_next;
                left     <= left - 5'd1;
                dp_valid <= 1'b1;
                dp_last  <= (left == 5'd1);
                if (wr_q) HWDATA <= wr_data;
            end else if (dp_valid && (HREADY || HRESP)) begin
                dp_valid <= 1'b0;
            end
            if (dp_ok) begin
                done <= dp_last;
                if (!wr_q) begin
                    rd_valid <= 1'b1;
                    rd_last  <= dp_last;
                    rd_data  <= HRDATA;
                end
            end
            if (abort) begin
                xfer_err <= 1'b1;
                left     <= 5'd0;
            end
        end
    end
endmodule

// File: tb/tb_ahb_lite_burst_manager.sv
// Directed bench for ahb_lite_burst_manager. The bench plays the subordinate:
// each cycle it drives HREADY/HRESP/HRDATA at the falling edge and checks the
// manager outputs 1 ns later against hand-computed values.
module tb_ahb_lite_burst_manager;
    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          HRESET;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [2:0]    cmd_burst, cmd_size;
    logic [4:0]    cmd_len;
    logic [3:0]    cmd_prot;
    logic [DW-1:0] wr_data;
    logic          wr_pop;
    logic [DW-1:0] rd_data;
    logic          rd_valid, rd_last, done, xfer_err, cmd_err;
    logic [AW-1:0] HADDR;
    logic [1:0]    HTRANS;
    logic          HWRITE;
    logic [2:0]    HSIZE, HBURST;
    logic [3:0]    HPROT;
    logic [DW-1:0] HWDATA, HRDATA;
    logic          HREADY, HRESP;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];

    ahb_lite_burst_manager #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_burst(cmd_burst), .cmd_size(cmd_size),
        .cmd_len(cmd_len), .cmd_prot(cmd_prot),
        .wr_data(wr_data), .wr_pop(wr_pop),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last),
        .done(done), .xfer_err(xfer_err), .cmd_err(cmd_err),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
    );

    // clock
    always #5 clk = ~clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // one bus cycle: drive subordinate response and write source, then settle
    task automatic bus(input logic rdy, input logic rsp, input logic [DW-1:0] rdat,
                       input logic [DW-1:0] wdat);
        @(negedge clk);
        cmd_valid = 1'b0;
        HREADY    = rdy;
        HRESP     = rsp;
        HRDATA    = rdat;
        wr_data   = wdat;
        #1;
    endtask

    // offer a command for one cycle; it is accepted on the next rising edge
    task automatic issue(input logic wr, input logic [AW-1:0] a, input logic [2:0] b,
                         input logic [2:0] s, input logic [4:0] l);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_burst = b;
        cmd_size  = s;
        cmd_len   = l;
        cmd_prot  = 4'h3;
        HREADY    = 1'b1;
        HRESP     = 1'b0;
        #1;
        check("cmd_ready_idle", cmd_ready, 1);
    endtask

    initial begin
        logic [AW-1:0] wrap4_a [4]  = '{32'h38, 32'h3C, 32'h30, 32'h34};
        logic          i8_rdy  [12] = '{1,1,1,0,0,1,1,1,1,1,1,1};
        logic [1:0]    i8_tr   [12] = '{2,3,3,3,3,3,3,3,3,3,0,0};
        logic [AW-1:0] i8_a    [12] = '{32'h200,32'h204,32'h208,32'h20C,32'h20C,32'h20C,
                                        32'h210,32'h214,32'h218,32'h21C,32'h21C,32'h21C};
        logic          i8_pop  [12] = '{1,1,1,0,0,1,1,1,1,1,0,0};
        int            i8_hw   [12] = '{0,0,1,2,2,2,3,4,5,6,7,7};
        logic [AW-1:0] bad_a   [4]  = '{32'h3F8, 32'h102, 32'h100, 32'h100};
        logic [2:0]    bad_b   [4]  = '{3'd1, 3'd0, 3'd1, 3'd0};
        logic [2:0]    bad_s   [4]  = '{3'd2, 3'd2, 3'd2, 3'd3};
        logic [4:0]    bad_l   [4]  = '{5'd3, 5'd0, 5'd0, 5'd0};
        int npop;
        int nrd;
        logic [DW-1:0] e;

        // reset
        HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
        cmd_burst = 3'd0; cmd_size = 3'd0; cmd_len = 5'd0; cmd_prot = 4'd0;
        wr_data = '0; HRDATA = '0; HREADY = 1'b1; HRESP = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("rst_htrans", HTRANS, 0);
        check("rst_haddr", HADDR, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_hwdata", HWDATA, 0);
        check("rst_done", done, 0);
        check("rst_rd_valid", rd_valid, 0);
        HRESET = 1'b0;

        // INCR4 write, size 2, 0x100, no waits
        issue(1'b1, 32'h100, 3'd3, 3'd2, 5'd0);
        npop = 0;
        for (int i = 0; i < 7; i++) begin
            bus(1'b1, 1'b0, '0, 32'hA000_0000 + DW'(i));
            if (wr_pop) npop++;
            if (i < 4) begin
                check("i4_htrans", HTRANS, (i == 0) ? 2 : 3);
                check("i4_haddr", HADDR, 32'h100 + 4 * i);
                check("i4_hburst", HBURST, 3);
                check("i4_hwrite", HWRITE, 1);
                check("i4_hsize", HSIZE, 2);
                check("i4_hprot", HPROT, 3);
                check("i4_wr_pop", wr_pop, 1);
            end else begin
                check("i4_htrans_idle", HTRANS, 0);
                check("i4_haddr_hold", HADDR, 32'h10C);
                check("i4_ctrl_idle", {HBURST, HSIZE, HWRITE, HPROT}, 0);
                check("i4_wr_pop_idle", wr_pop, 0);
            end
            if (i >= 1 && i <= 4) check("i4_hwdata", HWDATA, 32'hA000_0000 + i - 1);
            check("i4_done", done, i == 5);
            check("i4_cmd_ready", cmd_ready, i >= 5);
        end
        check("i4_pop_count", npop, 4);

        // WRAP4 read, size 2, 0x38
        issue(1'b0, 32'h38, 3'd2, 3'd2, 5'd0);
        nrd = 0;
        for (int i = 0; i < 7; i++) begin
            if (i >= 1 && i <= 4) begin
                e = 32'hD000_0000 + DW'(i);
                exp_q.push_back(e);
                bus(1'b1, 1'b0, e, '0);
            end else begin
                bus(1'b1, 1'b0, 32'hDEAD_BEEF, '0);
            end
            if (i < 4) begin
                check("w4_haddr", HADDR, wrap4_a[i]);
                check("w4_htrans", HTRANS, (i == 0) ? 2 : 3);
                check("w4_hburst", HBURST, 2);
                check("w4_hwrite", HWRITE, 0);
            end else begin
                check("w4_htrans_idle", HTRANS, 0);
            end
            check("w4_rd_valid", rd_valid, (i >= 2 && i <= 5));
            check("w4_rd_last", rd_last, i == 5);
            check("w4_done", done, i == 5);
            if (rd_valid && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("w4_rd_data", rd_data, e);
                nrd++;
            end
        end
        check("w4_rd_count", nrd, 4);
        check("w4_q_empty", exp_q.size(), 0);

        // INCR8 write, two wait states in beat 3's data phase
        issue(1'b1, 32'h200, 3'd5, 3'd2, 5'd0);
        npop = 0;
        for (int i = 0; i < 12; i++) begin
            bus(i8_rdy[i], 1'b0, '0, 32'hB000_0000 + DW'(npop));
            check("i8_htrans", HTRANS, i8_tr[i]);
            check("i8_haddr", HADDR, i8_a[i]);
            check("i8_wr_pop", wr_pop, i8_pop[i]);
            if (i >= 1) check("i8_hwdata", HWDATA, 32'hB000_0000 + i8_hw[i]);
            check("i8_done", done, i == 11);
            if (wr_pop) npop++;
        end
        check("i8_pop_count", npop, 8);

        // INCR16 read, ERROR on beat 2
        issue(1'b0, 32'h400, 3'd7, 3'd2, 5'd0);
        bus(1'b1, 1'b0, '0, '0);
        check("e16_htrans_n", HTRANS, 2);
        check("e16_haddr_0", HADDR, 32'h400);
        bus(1'b1, 1'b0, 32'h1234_5678, '0);
        check("e16_htrans_s", HTRANS, 3);
        bus(1'b0, 1'b1, 32'hFFFF_FFFF, '0);
        check("e16_haddr_2", HADDR, 32'h408);
        check("e16_rd_valid_b1", rd_valid, 1);
        check("e16_rd_data_b1", rd_data, 32'h1234_5678);
        check("e16_rd_last_b1", rd_last, 0);
        bus(1'b1, 1'b1, 32'hFFFF_FFFF, '0);
        check("e16_htrans_cancel", HTRANS, 0);
        check("e16_rd_valid_err", rd_valid, 0);
        check("e16_xfer_err_early", xfer_err, 0);
        bus(1'b1, 1'b0, '0, '0);
        check("e16_xfer_err", xfer_err, 1);
        check("e16_done", done, 0);
        check("e16_rd_valid_after", rd_valid, 0);
        check("e16_cmd_ready", cmd_ready, 1);
        check("e16_htrans_idle", HTRANS, 0);
        bus(1'b1, 1'b0, '0, '0);
        check("e16_xfer_err_pulse", xfer_err, 0);

        // illegal commands: 1 KB crossing, misaligned, INCR len 0, oversize
        for (int k = 0; k < 4; k++) begin
            issue(1'b0, bad_a[k], bad_b[k], bad_s[k], bad_l[k]);
            bus(1'b1, 1'b0, '0, '0);
            check("rej_cmd_err", cmd_err, 1);
            check("rej_htrans", HTRANS, 0);
            check("rej_cmd_ready", cmd_ready, 1);
            bus(1'b1, 1'b0, '0, '0);
            check("rej_cmd_err_pulse", cmd_err, 0);
            check("rej_htrans_2", HTRANS, 0);
        end

        // INCR len 2 ending exactly at 0x3FF is legal
        issue(1'b0, 32'h3F8, 3'd1, 3'd2, 5'd2);
        bus(1'b1, 1'b0, '0, '0);
        check("kb_ok_cmd_err", cmd_err, 0);
        check("kb_ok_htrans", HTRANS, 2);
        check("kb_ok_hburst", HBURST, 1);
        bus(1'b1, 1'b0, 32'h11, '0);
        check("kb_ok_haddr", HADDR, 32'h3FC);
        bus(1'b1, 1'b0, 32'h22, '0);
        check("kb_ok_htrans_idle", HTRANS, 0);
        bus(1'b1, 1'b0, '0, '0);
        check("kb_ok_done", done, 1);
        check("kb_ok_rd_data", rd_data, 32'h22);

        // reset during beat 5 of WRAP8 read at 0x84
        issue(1'b0, 32'h84, 3'd4, 3'd2, 5'd0);
        for (int i = 0; i < 5; i++) begin
            bus(1'b1, 1'b0, 32'hC0 + DW'(i), '0);
            if (i == 0) check("w8_haddr_0", HADDR, 32'h84);
        end
        check("w8_haddr_4", HADDR, 32'h94);
        check("w8_htrans_4", HTRANS, 3);
        HRESET = 1'b1;
        #1;
        check("arst_htrans", HTRANS, 0);
        check("arst_haddr", HADDR, 0);
        check("arst_hburst", HBURST, 0);
        check("arst_cmd_ready", cmd_ready, 0);
        check("arst_rd_valid", rd_valid, 0);
        @(negedge clk);
        HRESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus(1'b1, 1'b0, '0, '0);
            check("arst_done", done, 0);
            check("arst_xfer_err", xfer_err, 0);
            check("arst_htrans_idle", HTRANS, 0);
        end

        // SINGLE write after reset
        issue(1'b1, 32'h20, 3'd0, 3'd2, 5'd0);
        bus(1'b1, 1'b0, '0, 32'h5A5A_0001);
        check("sg_htrans", HTRANS, 2);
        check("sg_haddr", HADDR, 32'h20);
        check("sg_hburst", HBURST, 0);
        check("sg_hwrite", HWRITE, 1);
        check("sg_wr_pop", wr_pop, 1);
        bus(1'b1, 1'b0, '0, 32'h5A5A_0002);
        check("sg_htrans_idle", HTRANS, 0);
        check("sg_hwdata", HWDATA, 32'h5A5A_0001);
        check("sg_wr_pop_idle", wr_pop, 0);
        bus(1'b1, 1'b0, '0, '0);
        check("sg_done", done, 1);
        bus(1'b1, 1'b0, '0, '0);
        check("sg_done_pulse", done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
